// File: rtl/sn_decoder.sv
// Stochastic-to-binary decoder: popcounts bitstream beats over a frame and
// emits a saturated quantized value. Define SN_DECODER_BIPOLAR_EN for bipolar decode.
module sn_decoder #(
    parameter int BITSTREAM   = 64,
    parameter int FRAME_BEATS = 4,
    parameter int QUANT       = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [BITSTREAM-1:0]                         w_bitstream,
    input  logic                                         w_valid,
    input  logic                                         w_last,
    output logic                                         w_ready,
    output logic [QUANT-1:0]                             r_data,
    output logic [$clog2(BITSTREAM*FRAME_BEATS):0]       r_ones,
    output logic                                         r_short,
    output logic                                         r_valid,
    input  logic                                         r_ready
);

    localparam int N  = BITSTREAM * FRAME_BEATS;
    localparam int LN = $clog2(N);
    localparam int OW = LN + 1;
    localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int IW = LN + QUANT + 1;

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } state_t;

    state_t           state_q;
    logic [OW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             w_ready_q;
    logic             r_valid_q;
    logic [QUANT-1:0] r_data_q;
    logic [OW-1:0]    r_ones_q;
    logic             r_short_q;

    logic [OW-1:0]    pop;
    logic [OW-1:0]    sum;
    logic             last_beat;
    logic             close;
    logic [QUANT-1:0] q_val;

    always_comb begin
        pop = '0;
        for (int i = 0; i < BITSTREAM; i++) begin
            pop = pop + OW'(w_bitstream[i]);
        end
    end

    assign sum       = acc_q + pop;
    assign last_beat = (cnt_q == CW'(FRAME_BEATS - 1));
    assign close     = w_last | last_beat;

`ifdef SN_DECODER_BIPOLAR_EN
    localparam logic signed [IW:0] NS   = (IW+1)'(N);
    localparam logic signed [IW:0] BMAX = (IW+1)'((2**(QUANT-1)) - 1);
    localparam logic signed [IW:0] BMIN = (IW+1)'(-(2**(QUANT-1)));

    logic signed [IW:0] bd;
    logic signed [IW:0] bs;

    // (2*ones - N) scaled to QUANT-1 fraction bits, floor via arithmetic shift
    always_comb begin
        bd    = ($signed((IW+1)'(sum)) <<< 1) - NS;
        bs    = (bd <<< (QUANT - 1)) >>> LN;
        q_val = bs[QUANT-1:0];
        if (bs > BMAX) begin
            q_val = BMAX[QUANT-1:0];
        end else if (bs < BMIN) begin
            q_val = BMIN[QUANT-1:0];
        end
    end
`else
    localparam logic [IW-1:0] UMAX = IW'((2**QUANT) - 1);

    logic [IW-1:0] uq;

    always_comb begin
        uq    = (IW'(sum) << QUANT) >> LN;
        q_val = uq[QUANT-1:0];
        if (uq > UMAX) begin
            q_val = '1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            w_ready_q <= 1'b1;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_ones_q  <= '0;
            r_short_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (w_valid) begin
                        if (close) begin
                            r_ones_q  <= sum;
                            r_data_q  <= q_val;
                            r_short_q <= w_last & ~last_beat;
                            r_valid_q <= 1'b1;
                            w_ready_q <= 1'b0;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            state_q   <= ST_OUT;
                        end else begin
                            acc_q <= sum;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (r_ready) begin
                        r_valid_q <= 1'b0;
                        w_ready_q <= 1'b1;
                        state_q   <= ST_ACC;
                    end
                end
                default: begin
                    state_q   <= ST_ACC;
                    w_ready_q <= 1'b1;
                    r_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign w_ready = w_ready_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_ones  = r_ones_q;
    assign r_short = r_short_q;

endmodule

// File: doc/sn_decoder.md
Name: sn_decoder

Overview:
- Stochastic-to-binary converter; the receive end of the SNG bitstream path.
- Accepts BITSTREAM-wide bitstream beats over a valid/ready handshake and popcounts each beat.
- Accumulates the counts over a frame of up to FRAME_BEATS beats, then presents a saturated QUANT-bit binary value on an output valid/ready handshake.
- Sits after the stochastic compute array and feeds binary results back to the quantized datapath.

Parameters:
- BITSTREAM, 64, bits per input beat; power of two.
- FRAME_BEATS, 4, maximum beats per frame; power of two, >= 1.
- QUANT, 8, output value width; QUANT <= log2(BITSTREAM*FRAME_BEATS) + 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- w_bitstream  input  BITSTREAM  bitstream beat.
- w_valid  input  1  beat valid.
- w_last  input  1  last beat of frame; sampled only with w_valid & w_ready.
- w_ready  output  1  decoder accepts a beat this cycle.
- r_data  output  QUANT  decoded value.
- r_ones  output  $clog2(BITSTREAM*FRAME_BEATS)+1  raw ones count of the frame.
- r_short  output  1  frame closed by w_last before FRAME_BEATS beats.
- r_valid  output  1  result valid.
- r_ready  input  1  downstream accepts result.

Behaviour:
- Let N = BITSTREAM*FRAME_BEATS, LN = log2(N).
- Reset (async, rst_n low):
  - state = ACC; accumulator and beat counter = 0.
  - r_valid = 0, r_data = 0, r_ones = 0, r_short = 0.
  - w_ready = 1 on the first cycle after rst_n deasserts.
  - Reset mid-frame discards the partial frame; reset while r_valid=1 drops the pending result.
- State ACC:
  - w_ready = 1.
  - On each beat (w_valid & w_ready): acc += popcount(w_bitstream); beat counter += 1.
  - Closing beat: w_last=1, or beat counter == FRAME_BEATS-1 (the FRAME_BEATS-th beat); the first of the two closes the frame.
  - On the closing beat, the next edge latches:
    - r_ones = acc + popcount(closing beat);
    - r_data = quantized value (below);
    - r_short = w_last & (beat index < FRAME_BEATS-1);
    - r_valid = 1.
  - Then go to OUT and clear the accumulator and beat counter.
  - Latency: closing beat at edge N gives r_valid=1 after edge N; one cycle.
  - w_valid=0 cycles inside a frame are bubbles; state is held.
- State OUT:
  - w_ready = 0; r_* outputs stable while r_valid=1 and r_ready=0.
  - On r_valid & r_ready: r_valid = 0 next cycle and state returns to ACC; w_ready = 1 that same next cycle.
  - r_data, r_ones and r_short hold their last values after r_valid drops.
- Quantization (unipolar):
  - r_data = min(2^QUANT-1, (ones << QUANT) >> LN).
  - Intermediate width is LN+QUANT+1 bits; no overflow is permitted.
  - A short frame is scaled as though the missing beats were all zeros; no renormalisation.
- Popcount and add are combinational in ACC; the only output register stage is r_*.
- With FRAME_BEATS = 1, every accepted beat closes a frame; r_short is always 0.

Optional Feature:
- Macro: SN_DECODER_BIPOLAR_EN.
- Defined: bipolar decode.
  - r_data is signed two's complement: sat(((2*ones - N) << (QUANT-1)) >>> LN).
  - Saturation range is [-2^(QUANT-1), 2^(QUANT-1)-1], using an arithmetic shift.
  - r_ones is unchanged.
- Undefined: the unipolar formula above; no signed logic is synthesized.

Test Plan:
- Reset with w_valid=1 held: r_valid=0, w_ready=1 on the first cycle after rst_n rises; the first beat is accepted.
- Defaults, 4 beats of 0x0000_0000_FFFF_FFFF, w_last on beat 4: r_ones=128, r_data=128, r_short=0, r_valid one cycle after beat 4.
- 4 beats all-ones: r_ones=256, r_data saturates to 255.
  - With SN_DECODER_BIPOLAR_EN: r_data = 127, saturated.
  - All-zeros frame with SN_DECODER_BIPOLAR_EN: r_data = -128 (0x80).
- Short frame, 2 beats all-ones with w_last on beat 2: r_ones=128, r_data=128, r_short=1.
- No w_last for 4 beats: frame auto-closes on beat 4. Hold r_ready=0 for 5 cycles: w_ready=0 and r_* stable throughout. Raise r_ready: r_valid drops next cycle and w_ready returns to 1.
- Back-to-back frames with r_ready tied high and w_valid continuous: exactly one w_ready=0 bubble per frame; results match per-frame popcounts.
- rst_n pulsed low after 2 beats of a frame: the partial frame is discarded; the next 4 all-zero beats give r_ones=0.
